// File: rtl/cc_load_pkg.sv
// cc_load_pkg: shared types and defaults for the cc register-load sequencer.
package cc_load_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        LOAD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_SETTLE_CYCLES  = 2;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    // One counter serves both the settle window and the grant timeout, so it
    // is sized for the larger of the two (minimum 1 bit).
    function automatic int cnt_width(input int settle, input int timeout);
        int m;
        m = (settle > timeout) ? settle : timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cc_load_seq_if.sv
// cc_load_seq_if: upstream word handshake plus the cc register-load bus.
// master = the sequencer, slave = upstream source and bus together.
interface cc_load_seq_if
    import cc_load_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid_pad;
    logic              in_ready_pad;
    logic [DATA_W-1:0] in_data_pad;
    logic              in_mode_pad;
    logic              bus_en_pad;
    logic              bus_sel_pad;
    logic              bus_req_pad;
    logic              bus_grant_pad;
    logic              bus_load_pad;
    logic              bus_mode_pad;
    logic [DATA_W-1:0] bus_data_pad;
    logic              busy_pad;
    logic              err_pad;

    modport master (
        input  in_valid_pad, in_data_pad, in_mode_pad, bus_grant_pad,
        output in_ready_pad, bus_en_pad, bus_sel_pad, bus_req_pad,
               bus_load_pad, bus_mode_pad, bus_data_pad, busy_pad, err_pad
    );

    modport slave (
        output in_valid_pad, in_data_pad, in_mode_pad, bus_grant_pad,
        input  in_ready_pad, bus_en_pad, bus_sel_pad, bus_req_pad,
               bus_load_pad, bus_mode_pad, bus_data_pad, busy_pad, err_pad
    );
endinterface

// File: rtl/cc_load_timer.sv
// cc_load_timer: saturating down-counter; load wins over enable, holds at 0.
module cc_load_timer
    import cc_load_pkg::*;
#(
    parameter int CNT_W = cnt_width(DEF_SETTLE_CYCLES, DEF_TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    // Load a start value, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/cc_load_seq.sv
// cc_load_seq: accepts words over valid/ready and runs the cc register-load
// protocol (request, grant, one load strobe, settle hold).
// Optional feature: define CC_LOAD_TIMEOUT_EN to abandon a word when grant
// does not arrive within TIMEOUT_CYCLES REQ cycles (sets sticky err_pad).
module cc_load_seq
    import cc_load_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          clk_pad,
    input  logic          rst_pad,
    cc_load_seq_if.master io
);
    localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    // Timer is loaded with N-1 so that it reads zero in the Nth cycle.
    localparam logic [CNT_W-1:0] SETTLE_LD =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef CC_LOAD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_LD =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

    state_t           state;
    logic             accept;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    // in_ready_pad is only ever high in IDLE, so this is the acceptance strobe.
    assign accept = io.in_ready_pad & io.in_valid_pad;

    // Timer control: arm the timeout on acceptance, arm the settle window in LOAD.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        case (state)
`ifdef CC_LOAD_TIMEOUT_EN
            IDLE: begin
                tmr_load = accept;
                tmr_val  = TOUT_LD;
            end
            REQ:  tmr_en = 1'b1;
`endif
            LOAD: begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            SETTLE: tmr_en = 1'b1;
            default: ;
        endcase
    end

    cc_load_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk_pad),
        .rst      (rst_pad),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Protocol FSM; every output is registered and updated with the state it
    // belongs to. bus_data_pad/bus_mode_pad double as the word holding registers.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state           <= IDLE;
            io.in_ready_pad <= 1'b0;
            io.bus_en_pad   <= 1'b0;
            io.bus_sel_pad  <= 1'b0;
            io.bus_req_pad  <= 1'b0;
            io.bus_load_pad <= 1'b0;
            io.bus_mode_pad <= 1'b0;
            io.bus_data_pad <= '0;
            io.busy_pad     <= 1'b0;
            io.err_pad      <= 1'b0;
        end else begin
            io.bus_en_pad <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state           <= REQ;
                        io.in_ready_pad <= 1'b0;
                        io.busy_pad     <= 1'b1;
                        io.bus_sel_pad  <= 1'b1;
                        io.bus_req_pad  <= 1'b1;
                        io.bus_data_pad <= io.in_data_pad;
                        io.bus_mode_pad <= io.in_mode_pad;
                    end else begin
                        io.in_ready_pad <= 1'b1;
                    end
                end
                REQ: begin
                    // Grant is checked first so it wins over a same-cycle timeout.
                    if (io.bus_grant_pad) begin
                        state           <= LOAD;
                        io.bus_req_pad  <= 1'b0;
                        io.bus_load_pad <= 1'b1;
                        io.err_pad      <= 1'b0;
                    end
`ifdef CC_LOAD_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state           <= IDLE;
                        io.in_ready_pad <= 1'b1;
                        io.busy_pad     <= 1'b0;
                        io.bus_sel_pad  <= 1'b0;
                        io.bus_req_pad  <= 1'b0;
                        io.bus_data_pad <= '0;
                        io.bus_mode_pad <= 1'b0;
                        io.err_pad      <= 1'b1;
                    end
`endif
                end
                LOAD: begin
                    io.bus_load_pad <= 1'b0;
                    io.bus_sel_pad  <= 1'b0;
                    if (SETTLE_CYCLES == 0) begin
                        state           <= IDLE;
                        io.in_ready_pad <= 1'b1;
                        io.busy_pad     <= 1'b0;
                        io.bus_data_pad <= '0;
                        io.bus_mode_pad <= 1'b0;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state           <= IDLE;
                        io.in_ready_pad <= 1'b1;
                        io.busy_pad     <= 1'b0;
                        io.bus_data_pad <= '0;
                        io.bus_mode_pad <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cc_load_seq.sv
// tb_cc_load_seq: directed bench. Each phase plans words on a cycle timeline;
// the plan yields both the stimulus and the expected output of every cycle.
module tb_cc_load_seq;
    localparam int DW = 8;
    localparam int T  = 15;
    localparam int NC = 64;

    typedef struct packed {
        logic          rdy, en, sel, req, load, mode, busy, err;
        logic [DW-1:0] data;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cc_load_seq_if #(.DATA_W(DW)) if2 ();
    cc_load_seq_if #(.DATA_W(DW)) if0 ();

    cc_load_seq #(.DATA_W(DW), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(T)) dut (
        .clk_pad(clk), .rst_pad(rst), .io(if2.master));
    cc_load_seq #(.DATA_W(DW), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(T)) dut0 (
        .clk_pad(clk), .rst_pad(rst), .io(if0.master));

    obs_t o2, o0;
    assign o2 = {if2.in_ready_pad, if2.bus_en_pad, if2.bus_sel_pad, if2.bus_req_pad,
                 if2.bus_load_pad, if2.bus_mode_pad, if2.busy_pad, if2.err_pad, if2.bus_data_pad};
    assign o0 = {if0.in_ready_pad, if0.bus_en_pad, if0.bus_sel_pad, if0.bus_req_pad,
                 if0.bus_load_pad, if0.bus_mode_pad, if0.busy_pad, if0.err_pad, if0.bus_data_pad};

    obs_t          exp_q [NC];
    obs_t          obs_log [NC];
    bit            s_val [NC], s_mode [NC], s_gnt [NC], ev_set [NC], ev_clr [NC];
    logic [DW-1:0] s_dat [NC];
    int            S, ccyc, nreq_hi, checks, errors, nx;
    bit            use0, chk_on;
    int            load_cyc [$];
    obs_t          cmp_o;

    function automatic obs_t cur();
        return use0 ? o0 : o2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < NC; c++) begin
            s_val[c] = 0; s_mode[c] = 0; s_gnt[c] = 0; s_dat[c] = '0;
            ev_set[c] = 0; ev_clr[c] = 0; exp_q[c] = '0; obs_log[c] = '0;
            if (c > 0) begin
                exp_q[c].rdy = 1'b1;
                exp_q[c].en  = 1'b1;
            end
        end
    endtask

    task automatic busy_cycle(input int c, input logic [DW-1:0] d, input bit m,
                              input bit sl, input bit rq, input bit ld);
        exp_q[c].rdy  = 1'b0;
        exp_q[c].sel  = sl;
        exp_q[c].req  = rq;
        exp_q[c].load = ld;
        exp_q[c].busy = 1'b1;
        exp_q[c].data = d;
        exp_q[c].mode = m;
    endtask

    // Word offered in IDLE cycle a. g = REQ cycles up to and including the
    // grant cycle; g == 0 means the grant never comes. Upstream keeps valid
    // high with other data during REQ and the bus raises stray grants after
    // the load; both must be ignored.
    task automatic plan(input int a, input logic [DW-1:0] d, input bit m,
                        input int g, output int nxt);
        int nreq, l;
        nreq = (g == 0) ? T : g;
        s_val[a] = 1; s_dat[a] = d; s_mode[a] = m;
        for (int i = 1; i <= nreq; i++) begin
            busy_cycle(a + i, d, m, 1, 1, 0);
            s_val[a + i] = 1; s_dat[a + i] = ~d;
        end
        if (g == 0) begin
            ev_set[a + T + 1] = 1;
            nxt = a + T + 1;
        end else begin
            s_gnt[a + g] = 1;
            l = a + g + 1;
            busy_cycle(l, d, m, 1, 0, 1);
            ev_clr[l] = 1; s_gnt[l] = 1;
            for (int i = 1; i <= S; i++) begin
                busy_cycle(l + i, d, m, 0, 0, 0);
                s_gnt[l + i] = 1;
            end
            nxt = l + S + 1;
            s_gnt[nxt] = 1;
        end
    endtask

    // Sticky error: set by a timeout, cleared by a load.
    task automatic finalize();
        bit e = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (ev_set[c]) e = 1'b1;
            if (ev_clr[c]) e = 1'b0;
            exp_q[c].err = e;
        end
    endtask

    task automatic zero_in();
        if2.in_valid_pad = 0; if2.in_data_pad = '0; if2.in_mode_pad = 0; if2.bus_grant_pad = 0;
        if0.in_valid_pad = 0; if0.in_data_pad = '0; if0.in_mode_pad = 0; if0.bus_grant_pad = 0;
    endtask

    task automatic drive(input int c);
        zero_in();
        if (use0) begin
            if0.in_valid_pad = s_val[c]; if0.in_data_pad = s_dat[c];
            if0.in_mode_pad = s_mode[c]; if0.bus_grant_pad = s_gnt[c];
        end else begin
            if2.in_valid_pad = s_val[c]; if2.in_data_pad = s_dat[c];
            if2.in_mode_pad = s_mode[c]; if2.bus_grant_pad = s_gnt[c];
        end
    endtask

    task automatic run_phase(input int n);
        @(negedge clk);
        rst = 1'b1;
        zero_in();
        @(negedge clk);
        chk("reset_state", int'(cur()), 0);
        rst = 1'b0;
        ccyc = 0; nreq_hi = 0; load_cyc.delete();
        chk_on = 1'b1;
        for (int c = 0; c < n; c++) begin
            drive(c);
            @(negedge clk);
        end
        chk_on = 1'b0;
        zero_in();
    endtask

    // Per-cycle comparison against the planned timeline, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (chk_on && ccyc < NC - 1) begin
            ccyc++;
            cmp_o = cur();
            obs_log[ccyc] = cmp_o;
            checks++;
            if (cmp_o !== exp_q[ccyc]) begin
                errors++;
                $display("FAIL cycle%0d outputs(rdy,en,sel,req,load,mode,busy,err,data) act=%h exp=%h",
                         ccyc, cmp_o, exp_q[ccyc]);
            end
            if (cmp_o.load === 1'b1) load_cyc.push_back(ccyc);
            if (cmp_o.req === 1'b1) nreq_hi++;
        end
    end

    initial begin
        checks = 0; errors = 0; chk_on = 0; use0 = 0; S = 2;
        zero_in();

        // Three words with settle 2: grant after 2, 6 and 1 REQ cycles.
        use0 = 0; S = 2; clear_plan();
        plan(1, 8'hA5, 1'b0, 2, nx);
        plan(nx, 8'h3C, 1'b1, 6, nx);
        plan(nx, 8'h5A, 1'b1, 1, nx);
        finalize();
        run_phase(25);
        chk("p1_load_count", load_cyc.size(), 3);
        chk("p1_first_load_cycle", load_cyc[0], 4);
        chk("p1_load0_data", int'(obs_log[4].data), 8'hA5);
        chk("p1_load1_data", int'(obs_log[14].data), 8'h3C);
        chk("p1_settle_data", int'(obs_log[16].data), 8'h3C);
        chk("p1_req_cycles", nreq_hi, 9);
        chk("p1_ready_back", int'(obs_log[7].rdy), 1);

        // Settle 0, two streamed words with immediate grant.
        use0 = 1; S = 0; clear_plan();
        plan(1, 8'h01, 1'b0, 1, nx);
        plan(nx, 8'h02, 1'b0, 1, nx);
        finalize();
        run_phase(10);
        chk("p2_load_count", load_cyc.size(), 2);
        chk("p2_load_gap", load_cyc[1] - load_cyc[0], 3);
        chk("p2_load0_data", int'(obs_log[3].data), 8'h01);
        chk("p2_load1_data", int'(obs_log[6].data), 8'h02);

        use0 = 0; S = 2; clear_plan();
`ifdef CC_LOAD_TIMEOUT_EN
        // Timeout drop, recovery load, then grant on the last allowed REQ cycle.
        plan(1, 8'h77, 1'b1, 0, nx);
        plan(nx, 8'h88, 1'b0, 1, nx);
        plan(nx, 8'h99, 1'b1, T, nx);
        finalize();
        run_phase(44);
        chk("p3_req_last", int'(obs_log[16].req), 1);
        chk("p3_err_set", int'(obs_log[17].err), 1);
        chk("p3_idle_after_timeout", int'(obs_log[17].rdy), 1);
        chk("p3_err_cleared", int'(obs_log[19].err), 0);
        chk("p3_load_count", load_cyc.size(), 2);
        chk("p3_grant_wins_cycle", load_cyc[1], 38);
        chk("p3_grant_wins_err", int'(obs_log[38].err), 0);
`else
        // Without the timeout, REQ waits past TIMEOUT_CYCLES and err stays low.
        plan(1, 8'h77, 1'b1, 21, nx);
        finalize();
        run_phase(28);
        chk("p3_req_at16", int'(obs_log[16].req), 1);
        chk("p3_req_at22", int'(obs_log[22].req), 1);
        chk("p3_load_cycle", load_cyc[0], 23);
        chk("p3_err_low", int'(obs_log[23].err), 0);
`endif

        // Reset asserted mid-SETTLE: asynchronous clear, no replay afterwards.
        use0 = 0; S = 2; clear_plan();
        plan(1, 8'hC3, 1'b0, 1, nx);
        finalize();
        run_phase(4);
        chk("p4_load_before_reset", load_cyc.size(), 1);
        chk("p4_in_settle", int'(obs_log[4].busy), 1);
        rst = 1'b1;
        #1;
        chk("p4_async_reset", int'(cur()), 0);
        clear_plan();
        finalize();
        run_phase(10);
        chk("p4_no_reload", load_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
